csr_gpio_bank: RTL

Parametrised CSR-mapped GPIO bank for the pipelined RISC-V core: NUM_IN input channels and NUM_OUT output channels, each DATA_W bits wide, addressed by 12-bit CSR numbers from CSR_BASE. Adds input synchronisers, per-input change detection with sticky write-1-to-clear status, an interrupt mask and a registered irq. Sits beside the execute/writeback stages. The read port is issued in EX and returns data in WB. The write port is driven from WB.

---
 rtl/csr_gpio_bank.sv | 125 ++++++++++++
 1 files changed

// File: rtl/csr_gpio_bank.sv
// ---------------------------------------------------------------------------
// csr_gpio_bank : CSR-mapped GPIO bank with synchronised inputs, sticky
//                 change status (W1C), interrupt mask and registered irq.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csr_gpio_bank #(
  parameter int                 DATA_W      = 32,
  parameter int                 NUM_IN      = 2,
  parameter int                 NUM_OUT     = 2,
  parameter logic [11:0]        CSR_BASE    = 12'hF00,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  OUT_RESET   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_en,
  input  logic [11:0]               rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_hit,
  input  logic                      wr_en,
  input  logic [11:0]               wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [NUM_IN*DATA_W-1:0]  io_in,
  output logic [NUM_OUT*DATA_W-1:0] io_out,
  output logic                      irq
);

  localparam logic [11:0] C_N_MAP   = 12'(NUM_IN + NUM_OUT + 2);
  localparam logic [11:0] C_STATUS  = 12'(NUM_IN + NUM_OUT);
  localparam logic [11:0] C_MASK    = 12'(NUM_IN + NUM_OUT + 1);
  localparam logic [2:0]  C_ARM_INI = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][NUM_IN*DATA_W-1:0] r_sync;
  logic [NUM_IN*DATA_W-1:0]                  r_prev;
  logic [NUM_IN*DATA_W-1:0]                  w_in;
  logic [NUM_OUT-1:0][DATA_W-1:0]            r_out;
  logic [NUM_IN-1:0]                         r_status;
  logic [NUM_IN-1:0]                         r_mask;
  logic [NUM_IN-1:0]                         w_change;
  logic [NUM_IN-1:0]                         w_w1c;
  logic [2:0]                                r_arm;
  logic                                      w_armed;
  logic [11:0]                               w_rd_off;
  logic [11:0]                               w_wr_off;
  logic                                      w_rd_map;
  logic                                      w_wr_map;
  logic [DATA_W-1:0]                         w_rd_val;
  logic                                      w_rd_hit;
  logic [DATA_W-1:0]                         r_rd_data;
  logic                                      r_rd_hit;
  logic                                      r_irq;

  assign w_in     = r_sync[SYNC_STAGES-1];
  assign w_armed  = (r_arm == 3'd0);

  // The range check on the raw address guards against offset wrap-around.
  assign w_rd_off = rd_addr - CSR_BASE;
  assign w_wr_off = wr_addr - CSR_BASE;
  assign w_rd_map = (rd_addr >= CSR_BASE) && (w_rd_off < C_N_MAP);
  assign w_wr_map = (wr_addr >= CSR_BASE) && (w_wr_off < C_N_MAP);

  assign w_w1c = (wr_en && w_wr_map && (w_wr_off == C_STATUS)) ?
                 wr_data[NUM_IN-1:0] : '0;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_chg
    assign w_change[i] = w_armed &&
                         (w_in[i*DATA_W +: DATA_W] != r_prev[i*DATA_W +: DATA_W]);
  end

  always_comb begin
    w_rd_val = '0;
    w_rd_hit = 1'b0;
    if (rd_en && w_rd_map) begin
      w_rd_hit = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (w_rd_off == 12'(i)) w_rd_val = w_in[i*DATA_W +: DATA_W];
      end
      for (int j = 0; j < NUM_OUT; j++) begin
        if (w_rd_off == 12'(NUM_IN + j)) w_rd_val = r_out[j];
      end
      if (w_rd_off == C_STATUS) w_rd_val = DATA_W'(r_status);
      if (w_rd_off == C_MASK)   w_rd_val = DATA_W'(r_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_prev    <= '0;
      r_status  <= '0;
      r_mask    <= '0;
      r_arm     <= C_ARM_INI;
      r_rd_data <= '0;
      r_rd_hit  <= 1'b0;
      r_irq     <= 1'b0;
      for (int j = 0; j < NUM_OUT; j++) r_out[j] <= OUT_RESET;
    end else begin
      r_sync[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= w_in;
      if (r_arm != 3'd0) r_arm <= r_arm - 3'd1;
      // Set is OR'd in after the clear so a coincident detect wins.
      r_status <= (r_status & ~w_w1c) | w_change;
      if (wr_en && w_wr_map) begin
        for (int j = 0; j < NUM_OUT; j++) begin
          if (w_wr_off == 12'(NUM_IN + j)) r_out[j] <= wr_data;
        end
        if (w_wr_off == C_MASK) r_mask <= wr_data[NUM_IN-1:0];
      end
      r_rd_data <= w_rd_val;
      r_rd_hit  <= w_rd_hit;
      r_irq     <= |(r_status & r_mask);
    end
  end

  assign rd_data = r_rd_data;
  assign rd_hit  = r_rd_hit;
  assign io_out  = r_out;
  assign irq     = r_irq;

endmodule

`default_nettype wire
